// File: rtl/mac_operand_feeder.sv
// Operand feeder for the mac datapath: holds sample/coefficient banks and streams
// one frame of operand pairs per start request under a valid/ready handshake.
module mac_operand_feeder #(
    parameter int N_TAPS = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              op_clear,
    output logic              op_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] nextA_d, nextB_d;
    logic              valid_q, busy_q, done_q;
    logic [DATA_W-1:0] sample_q [N_TAPS];
    logic [DATA_W-1:0] coef_q   [N_TAPS];

    // Addresses at or beyond N_TAPS match no entry, so they fall away naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                sample_q[i] <= '0;
                coef_q[i]   <= '0;
            end
        end else if (cfg_we && !busy_q) begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (cfg_addr == ADDR_W'(i)) begin
                    if (cfg_sel) coef_q[i]   <= cfg_wdata;
                    else         sample_q[i] <= cfg_wdata;
                end
            end
        end
    end

    always_comb begin
        idx_d   = idx_q + 1'b1;
        nextA_d = '0;
        nextB_d = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (idx_d == ADDR_W'(i)) begin
                nextA_d = sample_q[i];
                nextB_d = coef_q[i];
            end
        end
    end

    // Pair registers only move on a handshake, which gives the stall hold for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ISSUE;
                        idx_q   <= '0;
                        a_q     <= sample_q[0];
                        b_q     <= coef_q[0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_d;
                            a_q   <= nextA_d;
                            b_q   <= nextB_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign op_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign op_clear = valid_q && (idx_q == '0);
    assign op_last  = valid_q && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a small accumulator model standing in
// for the mac block; expected sums are hand-computed.
module tb_mac_operand_feeder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, cfg_we, cfg_sel, op_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] a_out, b_out;
    logic       op_valid, op_clear, op_last, busy, done;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic       lst;
    } pair_t;

    pair_t       pairs[$];
    int unsigned acc = 0;
    int unsigned doneCount = 0;
    int          errorCount = 0;
    int          checkCount = 0;
    logic        stallPrev = 1'b0;
    logic [7:0]  prevA, prevB;
    logic        prevClr, prevLst;

    mac_operand_feeder #(.N_TAPS(N), .DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .a_out(a_out), .b_out(b_out),
        .op_valid(op_valid), .op_ready(op_ready), .op_clear(op_clear), .op_last(op_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Accumulator model of the mac block plus a hold check on every stalled cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       = 0;
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stallValid", op_valid, 1);
                checkOutput("stallA", a_out, prevA);
                checkOutput("stallB", b_out, prevB);
                checkOutput("stallClr", op_clear, prevClr);
                checkOutput("stallLst", op_last, prevLst);
            end
            stallPrev = op_valid && !op_ready;
            prevA = a_out; prevB = b_out; prevClr = op_clear; prevLst = op_last;
            if (op_valid && op_ready) begin
                pairs.push_back('{a_out, b_out, op_clear, op_last});
                acc = op_clear ? a_out * b_out : acc + a_out * b_out;
            end
            if (done) doneCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeCfg(input logic sel, input logic [1:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic runFrame(input string tag, input int unsigned expAcc);
        int n;
        pairs.delete();
        applyStimulus();
        waitDone(n);
        checkOutput({tag, ".latency"}, n, N);
        checkOutput({tag, ".acc"}, acc, expAcc);
        tick();
    endtask

    task automatic checkPairs(input string tag, input int unsigned expA[4], input int unsigned expB[4]);
        checkOutput({tag, ".count"}, pairs.size(), N);
        for (int i = 0; i < pairs.size() && i < N; i++) begin
            checkOutput($sformatf("%s.a%0d", tag, i), pairs[i].a, expA[i]);
            checkOutput($sformatf("%s.b%0d", tag, i), pairs[i].b, expB[i]);
            checkOutput($sformatf("%s.clr%0d", tag, i), pairs[i].clr, (i == 0) ? 1 : 0);
            checkOutput($sformatf("%s.lst%0d", tag, i), pairs[i].lst, (i == N - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        int unsigned doneBase;
        int unsigned seqA[4] = '{1, 2, 3, 4};
        int unsigned seqB[4] = '{5, 6, 7, 8};
        int          pat[7]  = '{1, 0, 0, 1, 0, 1, 1};

        rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; op_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("rst.a", a_out, 0);
        checkOutput("rst.b", b_out, 0);
        checkOutput("rst.valid", op_valid, 0);
        checkOutput("rst.clr", op_clear, 0);
        checkOutput("rst.lst", op_last, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);

        for (int i = 0; i < N; i++) begin
            writeCfg(1'b0, 2'(i), 8'(i + 1));
            writeCfg(1'b1, 2'(i), 8'(i + 5));
        end

        // Basic frame with op_ready held high.
        pairs.delete();
        applyStimulus();
        checkOutput("basic.validRise", op_valid, 1);
        checkOutput("basic.busy", busy, 1);
        waitDone(n);
        checkOutput("basic.latency", n, N);
        checkOutput("basic.validLow", op_valid, 0);
        checkOutput("basic.acc", acc, 70);
        checkPairs("basic", seqA, seqB);
        tick();
        checkOutput("basic.donePulse", done, 0);
        checkOutput("basic.idle", busy, 0);

        // Backpressure: handshakes land on edges 1, 4, 6 and 7.
        doneBase = doneCount;
        pairs.delete();
        applyStimulus();
        for (int i = 0; i < 7; i++) begin
            op_ready = pat[i][0];
            tick();
        end
        checkOutput("bp.done", done, 1);
        checkOutput("bp.acc", acc, 70);
        checkPairs("bp", seqA, seqB);
        op_ready = 1'b1;
        tick();
        checkOutput("bp.doneCount", doneCount - doneBase, 1);

        // Write to index 0 together with start: this frame sees the old sample.
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd9;
        pairs.delete();
        applyStimulus();
        cfg_we = 1'b0;
        waitDone(n);
        checkOutput("same.latency", n, N);
        checkOutput("same.acc", acc, 70);
        tick();
        runFrame("same2", 110);

        for (int i = 0; i < N; i++) begin
            writeCfg(1'b0, 2'(i), 8'd255);
            writeCfg(1'b1, 2'(i), 8'd255);
        end
        pairs.delete();
        applyStimulus();
        writeCfg(1'b0, 2'd3, 8'd0);
        waitDone(n);
        checkOutput("ovf.acc", acc, 260100);
        tick();
        runFrame("ovf2", 260100);

        // start held high: second frame only launches from the cycle after done.
        doneBase = doneCount;
        start = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            if (e == 4)  checkOutput("hold.done1", done, 1);
            if (e == 5)  checkOutput("hold.gapBusy", busy, 0);
            if (e == 5)  checkOutput("hold.gapValid", op_valid, 0);
            if (e == 6)  checkOutput("hold.restartClr", op_clear, 1);
            if (e == 10) checkOutput("hold.done2", done, 1);
        end
        start = 1'b0;
        repeat (4) tick();
        checkOutput("hold.doneCount", doneCount - doneBase, 2);
        checkOutput("hold.acc", acc, 260100);

        // Reset after the second handshake.
        applyStimulus();
        tick();
        tick();
        doneBase = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst.a", a_out, 0);
        checkOutput("mrst.b", b_out, 0);
        checkOutput("mrst.valid", op_valid, 0);
        checkOutput("mrst.lst", op_last, 0);
        checkOutput("mrst.busy", busy, 0);
        checkOutput("mrst.done", done, 0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        checkOutput("mrst.noDone", doneCount - doneBase, 0);
        runFrame("zeroBank", 0);
        checkOutput("zeroBank.count", pairs.size(), N);
        if (pairs.size() > 3) checkOutput("zeroBank.a3", pairs[3].a, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
